// File: rtl/decode_ctrl_unit_pkg.sv
// Shared opcode, immediate-select and control encodings for the decode stage.
package decode_ctrl_unit_pkg;

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned IMMS_W = 3;
  localparam int unsigned REG_W  = 5;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;

  localparam logic [IMMS_W-1:0] IMM_I    = 3'd0;
  localparam logic [IMMS_W-1:0] IMM_U    = 3'd1;
  localparam logic [IMMS_W-1:0] IMM_S    = 3'd2;
  localparam logic [IMMS_W-1:0] IMM_B    = 3'd3;
  localparam logic [IMMS_W-1:0] IMM_J    = 3'd4;
  localparam logic [IMMS_W-1:0] IMM_L    = 3'd5;
  localparam logic [IMMS_W-1:0] IMM_NONE = 3'd7;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Decoded control bundle for one instruction.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic       rs1_used;
    logic       rs2_used;
  } ctrl_t;

  // D->E pipeline register contents; all-zero is the bubble.
  typedef struct packed {
    logic              valid;
    logic              illegal;
    logic              reg_write;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              alu_src;
    logic [1:0]        result_src;
    logic [1:0]        alu_op;
    logic [2:0]        funct3;
    logic              funct7b;
    logic [IMMS_W-1:0] imm_sel;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
  } e_reg_t;

endpackage

// File: rtl/decode_ctrl_unit_main_decoder.sv
// Purely combinational opcode -> control bundle and immediate-select decoder.
module main_decoder
  import decode_ctrl_unit_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output ctrl_t             ctrl_c,
  output logic [IMMS_W-1:0] imm_sel_c
);

  // Opcode decode; unknown opcodes flag illegal with every write/flow control cleared.
  always_comb begin
    ctrl_c          = '0;
    ctrl_c.rs1_used = 1'b1;
    imm_sel_c       = IMM_NONE;
    unique case (opcode)
      OP_LOAD: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.result_src = RES_MEM;
        imm_sel_c         = IMM_L;
      end
      OP_IMM: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_FUNCT;
        imm_sel_c        = IMM_I;
      end
      OP_JALR: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.jump       = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.result_src = RES_PC4;
        imm_sel_c         = IMM_I;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.rs1_used  = 1'b0;
        imm_sel_c        = IMM_U;
      end
      OP_STORE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.rs2_used  = 1'b1;
        imm_sel_c        = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_c.branch   = 1'b1;
        ctrl_c.alu_op   = ALU_SUB;
        ctrl_c.rs2_used = 1'b1;
        imm_sel_c       = IMM_B;
      end
      OP_JAL: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.jump       = 1'b1;
        ctrl_c.result_src = RES_PC4;
        ctrl_c.rs1_used   = 1'b0;
        imm_sel_c         = IMM_J;
      end
      OP_R: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = ALU_FUNCT;
        ctrl_c.rs2_used  = 1'b1;
        imm_sel_c        = IMM_I;
      end
      default: begin
        ctrl_c.illegal = 1'b1;
        imm_sel_c      = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_unit.sv
// Decode-stage control: decode, D->E register, load-use / redirect hazards, event counters.
module decode_ctrl_unit
  import decode_ctrl_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   instrD,
  input  logic              validD,
  input  logic              pcSrcE,
  output logic [IMMS_W-1:0] immSelD,
  output logic [REG_W-1:0]  rs1D,
  output logic [REG_W-1:0]  rs2D,
  output logic              regWriteE,
  output logic              memWriteE,
  output logic              branchE,
  output logic              jumpE,
  output logic              aluSrcE,
  output logic [1:0]        resultSrcE,
  output logic [1:0]        aluOpE,
  output logic [2:0]        funct3E,
  output logic              funct7bE,
  output logic [IMMS_W-1:0] immSelE,
  output logic [REG_W-1:0]  rdE,
  output logic [REG_W-1:0]  rs1E,
  output logic [REG_W-1:0]  rs2E,
  output logic              validE,
  output logic              illegalE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [CNT_W-1:0]  loadStallCnt,
  output logic [CNT_W-1:0]  flushCnt
);

  ctrl_t             dec_c;
  logic [IMMS_W-1:0] imm_sel_c;
  logic              lw_stall_c;
  logic              flush_e_c;
  e_reg_t            e_q, e_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic              unused_instr_bits;

  main_decoder u_main_decoder (
    .opcode    (instrD[6:0]),
    .ctrl_c    (dec_c),
    .imm_sel_c (imm_sel_c)
  );

  assign immSelD = imm_sel_c;
  assign rs1D    = instrD[19:15];
  assign rs2D    = instrD[24:20];

  assign unused_instr_bits = &{1'b0, instrD[XLEN-1:31], instrD[29:25]};

  // Load-use hazard and stall/flush generation; a redirect overrides the stall.
  always_comb begin
    lw_stall_c = e_q.valid && (e_q.result_src == RES_MEM) && (e_q.rd != '0) && validD &&
                 ((dec_c.rs1_used && (rs1D == e_q.rd)) ||
                  (dec_c.rs2_used && (rs2D == e_q.rd)));
    flush_e_c  = lw_stall_c || pcSrcE;
    stallF     = lw_stall_c && !pcSrcE;
    stallD     = lw_stall_c && !pcSrcE;
    flushD     = pcSrcE;
    flushE     = flush_e_c;
  end

  // Next E contents: bubble on flush or empty D slot, otherwise the decoded D instruction.
  always_comb begin
    e_d = '0;
    if (!flush_e_c && validD) begin
      e_d.valid      = 1'b1;
      e_d.illegal    = dec_c.illegal;
      e_d.reg_write  = dec_c.reg_write;
      e_d.mem_write  = dec_c.mem_write;
      e_d.branch     = dec_c.branch;
      e_d.jump       = dec_c.jump;
      e_d.alu_src    = dec_c.alu_src;
      e_d.result_src = dec_c.result_src;
      e_d.alu_op     = dec_c.alu_op;
      e_d.funct3     = instrD[14:12];
      e_d.funct7b    = instrD[30];
      e_d.imm_sel    = imm_sel_c;
      e_d.rd         = instrD[11:7];
      e_d.rs1        = instrD[19:15];
      e_d.rs2        = instrD[24:20];
    end
  end

  // Saturating hazard event counters.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (lw_stall_c && !pcSrcE && (ld_cnt_q != '1)) begin
      ld_cnt_d = ld_cnt_q + CNT_W'(1);
    end
    if (pcSrcE && (fl_cnt_q != '1)) begin
      fl_cnt_d = fl_cnt_q + CNT_W'(1);
    end
  end

  // D->E register and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q      <= '0;
      ld_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      ld_cnt_q <= ld_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign regWriteE    = e_q.reg_write;
  assign memWriteE    = e_q.mem_write;
  assign branchE      = e_q.branch;
  assign jumpE        = e_q.jump;
  assign aluSrcE      = e_q.alu_src;
  assign resultSrcE   = e_q.result_src;
  assign aluOpE       = e_q.alu_op;
  assign funct3E      = e_q.funct3;
  assign funct7bE     = e_q.funct7b;
  assign immSelE      = e_q.imm_sel;
  assign rdE          = e_q.rd;
  assign rs1E         = e_q.rs1;
  assign rs2E         = e_q.rs2;
  assign validE       = e_q.valid;
  assign illegalE     = e_q.illegal;
  assign loadStallCnt = ld_cnt_q;
  assign flushCnt     = fl_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// Randomized + directed bench for decode_ctrl_unit against a spec-level reference model.
module tb_decode_ctrl_unit;

  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, validD, pcSrcE;
  logic [31:0] instrD;
  logic [2:0] immSelD, funct3E, immSelE;
  logic [4:0] rs1D, rs2D, rdE, rs1E, rs2E;
  logic regWriteE, memWriteE, branchE, jumpE, aluSrcE, funct7bE, validE, illegalE;
  logic [1:0] resultSrcE, aluOpE;
  logic stallF, stallD, flushD, flushE;
  logic [CW-1:0] loadStallCnt, flushCnt;

  always #5 clk = ~clk;

  decode_ctrl_unit #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .pcSrcE(pcSrcE),
    .immSelD(immSelD), .rs1D(rs1D), .rs2D(rs2D),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .branchE(branchE), .jumpE(jumpE),
    .aluSrcE(aluSrcE), .resultSrcE(resultSrcE), .aluOpE(aluOpE), .funct3E(funct3E),
    .funct7bE(funct7bE), .immSelE(immSelE), .rdE(rdE), .rs1E(rs1E), .rs2E(rs2E),
    .validE(validE), .illegalE(illegalE), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .loadStallCnt(loadStallCnt), .flushCnt(flushCnt)
  );

  // Reference E-stage view of an instruction, straight from the RV32I rules.
  typedef struct {
    bit v, ill, rw, mw, br, jp, as, f7;
    bit [1:0] rs, ao;
    bit [2:0] f3, is;
    bit [4:0] rd, r1, r2;
  } me_t;

  me_t m_e;
  int  m_ld, m_fl;
  int  checks = 0, failures = 0;
  bit  chk_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic me_t ref_decode(input logic [31:0] ins);
    me_t m;
    logic [6:0] op;
    op = ins[6:0];
    m = '{default: 0};
    m.v = 1; m.f3 = ins[14:12]; m.f7 = ins[30];
    m.rd = ins[11:7]; m.r1 = ins[19:15]; m.r2 = ins[24:20];
    case (op)
      7'b0000011: begin m.rw = 1; m.as = 1; m.rs = 2'b01; m.is = 5; end
      7'b0010011: begin m.rw = 1; m.as = 1; m.ao = 2'b10; m.is = 0; end
      7'b1100111: begin m.rw = 1; m.jp = 1; m.as = 1; m.rs = 2'b10; m.is = 0; end
      7'b0110111,
      7'b0010111: begin m.rw = 1; m.as = 1; m.is = 1; end
      7'b0100011: begin m.mw = 1; m.as = 1; m.is = 2; end
      7'b1100011: begin m.br = 1; m.ao = 2'b01; m.is = 3; end
      7'b1101111: begin m.rw = 1; m.jp = 1; m.rs = 2'b10; m.is = 4; end
      7'b0110011: begin m.rw = 1; m.ao = 2'b10; m.is = 0; end
      default:    begin m.ill = 1; m.is = 7; end
    endcase
    return m;
  endfunction

  function automatic bit ref_lw_stall(input logic [31:0] ins, input bit vd);
    logic [6:0] op;
    bit u1, u2;
    op = ins[6:0];
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    return vd && m_e.v && (m_e.rs == 2'b01) && (m_e.rd != 0) &&
           ((u1 && ins[19:15] == m_e.rd) || (u2 && ins[24:20] == m_e.rd));
  endfunction

  // Drive one cycle's inputs after the falling edge and compare every output to the model.
  task automatic drive(input logic [31:0] ins, input bit vd, input bit pc, input bit r);
    bit lw;
    @(negedge clk);
    instrD = ins; validD = vd; pcSrcE = pc; rst = r;
    #1;
    if (chk_en) begin
      lw = ref_lw_stall(ins, vd);
      check_eq("immSelD", 32'(immSelD), 32'(ref_decode(ins).is));
      check_eq("rs1D", 32'(rs1D), 32'(ins[19:15]));
      check_eq("rs2D", 32'(rs2D), 32'(ins[24:20]));
      check_eq("stallF", 32'(stallF), 32'(lw && !pc));
      check_eq("stallD", 32'(stallD), 32'(lw && !pc));
      check_eq("flushD", 32'(flushD), 32'(pc));
      check_eq("flushE", 32'(flushE), 32'(lw || pc));
      check_eq("validE", 32'(validE), 32'(m_e.v));
      check_eq("illegalE", 32'(illegalE), 32'(m_e.ill));
      check_eq("ctrlE", {27'd0, regWriteE, memWriteE, branchE, jumpE, aluSrcE},
               {27'd0, m_e.rw, m_e.mw, m_e.br, m_e.jp, m_e.as});
      check_eq("resultSrcE", 32'(resultSrcE), 32'(m_e.rs));
      check_eq("aluOpE", 32'(aluOpE), 32'(m_e.ao));
      check_eq("functE", {28'd0, funct7bE, funct3E}, {28'd0, m_e.f7, m_e.f3});
      check_eq("immSelE", 32'(immSelE), 32'(m_e.is));
      check_eq("regsE", {17'd0, rdE, rs1E, rs2E}, {17'd0, m_e.rd, m_e.r1, m_e.r2});
      check_eq("loadStallCnt", 32'(loadStallCnt), 32'(m_ld));
      check_eq("flushCnt", 32'(flushCnt), 32'(m_fl));
    end
  endtask

  // Advance through the rising edge and update the model from the driven inputs.
  task automatic edge_step();
    bit lw;
    @(posedge clk);
    lw = ref_lw_stall(instrD, validD);
    if (rst) begin
      m_e = '{default: 0}; m_ld = 0; m_fl = 0;
    end else begin
      if (lw && !pcSrcE && m_ld < CMAX) m_ld++;
      if (pcSrcE && m_fl < CMAX) m_fl++;
      if (lw || pcSrcE || !validD) m_e = '{default: 0};
      else m_e = ref_decode(instrD);
    end
    #1;
  endtask

  task automatic cyc(input logic [31:0] ins, input bit vd, input bit pc);
    drive(ins, vd, pc, 1'b0);
    edge_step();
  endtask

  task automatic do_reset();
    drive($urandom, 1'b1, 1'b0, 1'b1);
    edge_step();
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, 3'b010, rd, op};
  endfunction

  logic [6:0] ops [10];
  logic [2:0] sweep_exp [9];
  logic [31:0] ins;

  initial begin
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0110111, 7'b0010111,
            7'b0100011, 7'b1100011, 7'b1101111, 7'b0110011, 7'b0001111};
    sweep_exp = '{3'd5, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    m_e = '{default: 0}; m_ld = 0; m_fl = 0;

    // Reset held two cycles with random instructions; second cycle is checked.
    chk_en = 0;
    drive($urandom, 1'b1, 1'b0, 1'b1);
    edge_step();
    chk_en = 1;
    do_reset();

    // Opcode sweep.
    for (int i = 0; i < 9; i++) begin
      drive(mk(ops[i], 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
      check_eq("sweep_immSelD", 32'(immSelD), 32'(sweep_exp[i]));
      edge_step();
    end
    drive(mk(7'b0001111, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    check_eq("illegal_immSelD", 32'(immSelD), 32'd7);
    edge_step();
    check_eq("illegal_illegalE", 32'(illegalE), 32'd1);
    check_eq("illegal_regWriteE", 32'(regWriteE), 32'd0);

    // Load-use: lw x5 then add x6,x5,x1 held while stalled.
    do_reset();
    cyc(mk(7'b0000011, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0);
    drive(mk(7'b0110011, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    check_eq("lu_stallF", 32'(stallF), 32'd1);
    check_eq("lu_flushE", 32'(flushE), 32'd1);
    edge_step();
    drive(mk(7'b0110011, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    check_eq("lu_bubble_validE", 32'(validE), 32'd0);
    check_eq("lu_stall_once", 32'(stallF), 32'd0);
    edge_step();
    drive(mk(7'b0010011, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    check_eq("lu_rdE", 32'(rdE), 32'd6);
    check_eq("lu_cnt", 32'(loadStallCnt), 32'd1);
    edge_step();

    // No false stalls.
    cyc(mk(7'b0000011, 5'd0, 5'd2, 5'd0), 1'b1, 1'b0);
    drive(mk(7'b0110011, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    check_eq("nf_x0", 32'(stallF), 32'd0);
    edge_step();
    cyc(mk(7'b0000011, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0);
    drive(mk(7'b0110111, 5'd5, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
    check_eq("nf_lui", 32'(stallF), 32'd0);
    edge_step();
    cyc(mk(7'b0000011, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0);
    drive(mk(7'b1101111, 5'd1, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0);
    check_eq("nf_jal", 32'(stallF), 32'd0);
    edge_step();

    // Redirect, alone and together with a load-use condition.
    do_reset();
    drive(mk(7'b0010011, 5'd7, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
    check_eq("rd_flushD", 32'(flushD), 32'd1);
    check_eq("rd_flushE", 32'(flushE), 32'd1);
    edge_step();
    check_eq("rd_bubble", 32'(validE), 32'd0);
    check_eq("rd_cnt", 32'(flushCnt), 32'd1);
    cyc(mk(7'b0000011, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0);
    drive(mk(7'b0110011, 5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 1'b0);
    check_eq("both_stallF", 32'(stallF), 32'd0);
    check_eq("both_flushE", 32'(flushE), 32'd1);
    edge_step();
    check_eq("both_flushCnt", 32'(flushCnt), 32'd2);
    check_eq("both_ldCnt", 32'(loadStallCnt), 32'd0);

    // Reset asserted mid-stall.
    cyc(mk(7'b0000011, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0);
    drive(mk(7'b0110011, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b1);
    check_eq("rstmid_stall", 32'(stallF), 32'd1);
    edge_step();
    drive(mk(7'b0110011, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    check_eq("rstmid_drop", 32'(stallF), 32'd0);
    edge_step();

    // Saturation: 20 load-use stalls.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(mk(7'b0000011, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0);
      cyc(mk(7'b0110011, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0);
      cyc(mk(7'b0110011, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0);
    end
    check_eq("sat_ldCnt", 32'(loadStallCnt), 32'd15);

    // Randomized traffic; D is held while the DUT stalls, as the front end would.
    do_reset();
    ins = 32'h13;
    for (int i = 0; i < 600; i++) begin
      if (!(stallD && validD)) begin
        ins = $urandom;
        ins[6:0] = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
        ins[11:7] = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      drive(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 59) == 0));
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
